// File: rtl/rr_priority_arbiter_16.sv
//------------------------------------------------------------------------------
// Module   : rr_priority_arbiter_16
// Purpose  : 16-client round-robin arbiter with held grant and release handshake.
//            Optional forced release after MAX_HOLD cycles under HOLD_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_arbiter_16 #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        release_i,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_gnt, w_gnt_nxt;
  logic [3:0]  r_gnt_id, w_gnt_id_nxt;
  logic [3:0]  r_ptr, w_ptr_nxt;
  logic [3:0]  w_winner;
  logic        w_found;
  logic        w_normal_rel;
  logic        w_hold_expired;
  logic        w_release;

  // Descending search starting at the pointer; first set request wins.
  always_comb begin
    w_winner = 4'd0;
    w_found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!w_found && req[r_ptr - 4'(i)]) begin
        w_winner = r_ptr - 4'(i);
        w_found  = 1'b1;
      end
    end
  end

  assign w_normal_rel = release_i || !req[r_gnt_id];
  assign w_release    = w_normal_rel || w_hold_expired;

`ifdef HOLD_TIMEOUT_EN
  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  assign w_hold_expired = (r_hold_cnt == c_max_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_hold_cnt <= w_found ? 8'd1 : 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_release ? 8'd0 : r_hold_cnt + 8'd1;
      // A genuine release in the same cycle masks the timeout indication.
      r_timeout  <= w_hold_expired && !w_normal_rel;
    end
  end

  assign timeout_o = r_timeout;
`else
  localparam int c_unused_max_hold = MAX_HOLD;

  assign w_hold_expired = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 16'd0;
      r_gnt_id <= 4'd0;
      r_ptr    <= 4'd15;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = 16'd1 << w_winner;
          w_gnt_id_nxt = w_winner;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt  = ST_IDLE;
          w_gnt_nxt    = 16'd0;
          w_gnt_id_nxt = 4'd0;
          // Next search starts just below the previous owner (wraps 0 -> 15).
          w_ptr_nxt    = r_gnt_id - 4'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_gnt_nxt    = 16'd0;
        w_gnt_id_nxt = 4'd0;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: doc/rr_priority_arbiter_16.md
Name: rr_priority_arbiter_16

Overview:
- Sequential 16-requester arbiter that shares one resource among 16 clients.
- Built around the 16:1 priority-encoding function: a one-hot/ID grant is picked by a priority search over a 16-bit request vector.
- The search start point rotates after every grant (round-robin), and the grant is held under a request/release handshake.
- Sits in front of any shared datapath that needs a 4-bit owner ID and exclusive ownership.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. Used only when HOLD_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk        input   1   system clock; all logic on the rising edge
- rst        input   1   reset; one clock; reset is synchronous and active-high
- req        input   16  request vector; bit k = client k requests
- release_i  input   1   current owner finished; sampled only while gnt_valid=1
- gnt        output  16  one-hot grant, registered
- gnt_id     output  4   binary index of the granted client, registered
- gnt_valid  output  1   a grant is active
- timeout_o  output  1   one-cycle pulse when a grant is force-released (always 0 when the feature is compiled out)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout_o=0, ptr=15, hold_cnt=0. Reset overrides everything, including during GRANT.
- Priority search:
  - Candidates are examined in order ptr, ptr-1, …, 0, 15, …, ptr+1 (mod 16, descending).
  - The first set req bit wins.
  - After reset this is a plain MSB-first priority encoder: bit 15 is highest.
- State IDLE:
  - gnt_valid=0.
  - If req≠0 at an edge: go to GRANT; gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1.
  - Latency: request sampled at edge N, grant visible after edge N.
  - If req=0: stay in IDLE.
- State GRANT:
  - gnt, gnt_id and gnt_valid are held stable.
  - The owner's req bit is the only one monitored; other req changes are ignored.
- Leaving GRANT: at an edge, release if any of the following holds:
  - (a) release_i=1;
  - (b) req[gnt_id]=0, an implicit release;
  - (c) timeout, when enabled.
- On release:
  - next state IDLE; gnt=0, gnt_id=0, gnt_valid=0;
  - ptr=(gnt_id−1) mod 16, so gnt_id=0 gives ptr=15.
- Grant spacing: there is always exactly one IDLE cycle between consecutive grants, so the minimum grant period is 2 cycles.
- Simultaneous events:
  - release_i and the owner dropping req in the same cycle count as a single release.
  - release_i while gnt_valid=0 is ignored.
- Fairness: a continuously requesting client is granted within 16 grant periods.
- Invariants: gnt is either zero or exactly one-hot; gnt == (gnt_valid << gnt_id).

Optional Feature:
- Macro HOLD_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bit) increments each GRANT cycle.
  - When hold_cnt==MAX_HOLD at an edge and neither release_i nor req drop occurred, the arbiter force-releases, treated exactly as a release.
  - gnt is therefore high for exactly MAX_HOLD cycles.
  - timeout_o=1 during the following IDLE cycle only.
  - A normal release in the same cycle as the timeout gives timeout_o=0.
- Undefined:
  - No counter; a grant is held indefinitely until release.
  - timeout_o is tied to 0.

Test Plan:
- Reset, then req=16'h0000 for 10 cycles -> gnt_valid=0, gnt=0, gnt_id=0 throughout; timeout_o=0.
- Reset, req=16'hFFFF, pulse release_i one cycle after each grant -> gnt_id sequence 15,14,13,…,0,15, each grant separated by one IDLE cycle.
- req=16'b1001_0110_0011_1001 held, release each grant after 1 cycle -> gnt_id 15,12,10,9,5,4,3,0,15. Check gnt one-hot matches gnt_id each time.
- Implicit release: grant to 5 (req=16'h0020); drop req to 16'h0000 while granted -> next cycle gnt_valid=0, ptr=4; set req=16'h0030 -> gnt_id=4.
- Reset mid-operation: rst=1 while gnt_id=9 -> after that edge all outputs 0; next grant with req=16'h8200 is 15.
- HOLD_TIMEOUT_EN defined, MAX_HOLD=4, req=16'h0008, no release_i:
  - gnt_valid high exactly 4 cycles;
  - then timeout_o=1 for 1 cycle with gnt_valid=0;
  - then gnt_id=3 re-granted.
  - Same stimulus without the macro -> grant held 50+ cycles, timeout_o=0.
